// File: rtl/kf76489_write_arbiter_pkg.sv
// Shared definitions for the KF76489 write path: register indices, command-byte
// bit positions (TI numbering, bit0 = latch flag) and the scheduler state type.
package KF76489_Pkg;

  localparam logic [2:0] TONE0_FREQ = 3'd0;
  localparam logic [2:0] TONE0_ATTN = 3'd1;
  localparam logic [2:0] TONE1_FREQ = 3'd2;
  localparam logic [2:0] TONE1_ATTN = 3'd3;
  localparam logic [2:0] TONE2_FREQ = 3'd4;
  localparam logic [2:0] TONE2_ATTN = 3'd5;
  localparam logic [2:0] NOISE_CTRL = 3'd6;
  localparam logic [2:0] NOISE_ATTN = 3'd7;

  localparam int LATCH_BIT = 0;
  localparam int CHAN_LSB  = 1;
  localparam int CHAN_MSB  = 2;
  localparam int TYPE_BIT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // Register index addressed by a latch byte: {channel, type}.
  function automatic logic [2:0] latch_index(input logic [7:0] cmd);
    return {cmd[CHAN_MSB:CHAN_LSB], cmd[TYPE_BIT]};
  endfunction

endpackage

// File: rtl/kf76489_write_arbiter_busy_timer.sv
// Loadable down-counter advanced only on chip ticks; o_done flags the tick
// that takes the count from 1 to 0.
module kf76489_busy_timer
  import KF76489_Pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = i_tick && (r_count == WIDTH'(1));

endmodule

// File: rtl/kf76489_write_arbiter.sv
// Two-port round-robin write scheduler for the KF76489 register file: grants a
// command byte, strobes its register for one cycle, then waits out the chip busy window.
module kf76489_write_arbiter
  import KF76489_Pkg::*;
#(
  parameter int BUSY_TICKS   = 32,
  parameter int LOCK_TIMEOUT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_enable,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  output logic [1:0]  req_ready,
  output logic [7:0]  internal_data_bus,
  output logic [7:0]  write_strobe,
  output logic        write_data_byte,
  output logic        chip_ready
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_TIMEOUT - 1);

  state_t     r_state;
  logic       r_last_served;
  logic       r_lock;
  logic       r_lock_port;
  logic [3:0] r_lock_cnt;
  logic [2:0] r_latched_idx;

  logic       w_grant;
  logic       w_hs;
  logic       w_is_latch;
  logic       w_busy_done;
  logic [7:0] w_byte;
  logic [2:0] w_idx;

  // A held lock pins the grant; otherwise a lone requester wins, and a tie
  // (or no requester) points at the port not served last.
  always_comb begin
    w_grant = ~r_last_served;
    if (r_lock) begin
      w_grant = r_lock_port;
    end else if (req_valid[0] ^ req_valid[1]) begin
      w_grant = req_valid[1];
    end
  end

  assign req_ready  = (reset && (r_state == ST_IDLE)) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_hs       = |(req_valid & req_ready);
  assign w_byte     = w_grant ? req_data[15:8] : req_data[7:0];
  assign w_is_latch = w_byte[LATCH_BIT];
  assign w_idx      = w_is_latch ? latch_index(w_byte) : r_latched_idx;
  assign chip_ready = (r_state == ST_IDLE);

  kf76489_busy_timer #(
    .WIDTH(8)
  ) u_busy_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (r_state == ST_ISSUE),
    .i_load_val (8'(BUSY_TICKS)),
    .i_tick     (clock_enable && (r_state == ST_BUSY)),
    .o_done     (w_busy_done)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state           <= ST_IDLE;
      r_last_served     <= 1'b1;
      r_lock            <= 1'b0;
      r_lock_port       <= 1'b0;
      r_lock_cnt        <= '0;
      r_latched_idx     <= TONE0_FREQ;
      internal_data_bus <= 8'h00;
      write_strobe      <= 8'h00;
      write_data_byte   <= 1'b0;
    end else begin
      write_strobe <= 8'h00;
      unique case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            // Outputs are registered here so they are presented during ISSUE.
            r_state           <= ST_ISSUE;
            r_last_served     <= w_grant;
            internal_data_bus <= w_byte;
            write_strobe      <= 8'b1 << w_idx;
            write_data_byte   <= ~w_is_latch;
            r_latched_idx     <= w_idx;
            r_lock            <= w_is_latch;
            r_lock_port       <= w_grant;
            r_lock_cnt        <= '0;
          end else if (r_lock) begin
            // No handshake under lock means the locked port is idle this cycle.
            if (r_lock_cnt == LOCK_LAST) begin
              r_lock     <= 1'b0;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + 4'd1;
            end
          end
        end
        ST_ISSUE: r_state <= ST_BUSY;
        ST_BUSY: begin
          if (w_busy_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kf76489_write_arbiter.sv
// Scoreboard bench for kf76489_write_arbiter: a rule-level model predicts grants and
// busy windows and queues expected writes; a monitor pops them when strobes appear.
module tb_kf76489_write_arbiter;

  localparam int BT = 32;
  localparam int LT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clock_enable = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_ready;
  logic [7:0]  internal_data_bus;
  logic [7:0]  write_strobe;
  logic        write_data_byte;
  logic        chip_ready;

  kf76489_write_arbiter #(
    .BUSY_TICKS   (BT),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .clock_enable      (clock_enable),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .internal_data_bus (internal_data_bus),
    .write_strobe      (write_strobe),
    .write_data_byte   (write_data_byte),
    .chip_ready        (chip_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] strobe;
    logic [7:0] bus;
    logic       wdb;
    int         due;
  } exp_t;
  exp_t sbq[$];

  // Handshakes as observed, for the stimulus side only.
  logic [1:0] acc = 2'b00;
  always @(negedge clock) acc = req_valid & req_ready;

  // Reference model: spec rules expressed as "pending issue", "ticks still to see",
  // last-served port, lock owner and idle-cycle count, and the last latched register.
  bit m_issue = 0;
  int m_ticks = 0;
  int m_last = 1;
  bit m_lock = 0;
  int m_lp = 0;
  int m_tc = 0;
  int m_idx = 0;
  bit m_rst_chk = 0;

  always @(negedge clock) begin
    int g;
    int bi;
    bit idle;
    logic [7:0] b;
    exp_t e;
    if (!reset) begin
      chk("ready_in_reset", req_ready, 0);
      m_issue = 0; m_ticks = 0; m_last = 1; m_lock = 0; m_lp = 0; m_tc = 0; m_idx = 0;
      m_rst_chk = 1;
    end else begin
      if (m_rst_chk) begin
        chk("post_reset_strobe", write_strobe, 0);
        chk("post_reset_bus", internal_data_bus, 0);
        chk("post_reset_wdb", write_data_byte, 0);
        m_rst_chk = 0;
      end
      idle = !m_issue && (m_ticks == 0);
      chk("chip_ready", chip_ready, idle);
      if (m_lock) g = m_lp;
      else if (req_valid == 2'b01) g = 0;
      else if (req_valid == 2'b10) g = 1;
      else g = 1 - m_last;
      if (!idle) chk("ready_not_idle", req_ready, 0);
      else if (!m_lock && req_valid == 2'b00) chk("ready_onehot", int'($onehot(req_ready)), 1);
      else chk("ready_grant", req_ready, 1 << g);

      if (m_issue) begin
        m_issue = 0;
        m_ticks = BT;
      end else if (m_ticks > 0 && clock_enable) begin
        m_ticks--;
      end

      if (idle && req_valid[g]) begin
        b = g ? req_data[15:8] : req_data[7:0];
        bi = int'(b);
        if (bi % 2 == 1) begin
          m_idx = 2 * ((bi / 2) % 4) + (bi / 8) % 2;
          m_lock = 1;
          m_lp = g;
        end else begin
          m_lock = 0;
        end
        m_tc = 0;
        m_last = g;
        m_issue = 1;
        e.strobe = 8'(1 << m_idx);
        e.bus = b;
        e.wdb = (bi % 2 == 0);
        e.due = cyc + 1;
        sbq.push_back(e);
      end else if (idle && m_lock) begin
        m_tc++;
        if (m_tc == LT) begin
          m_lock = 0;
          m_tc = 0;
        end
      end
    end
  end

  // Monitor: every strobe must match the oldest queued write, on its due cycle.
  always @(negedge clock) begin
    exp_t e;
    if (write_strobe != 8'h00) begin
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", write_strobe, 0);
      end else begin
        e = sbq.pop_front();
        chk("strobe", write_strobe, e.strobe);
        chk("bus", internal_data_bus, e.bus);
        chk("write_data_byte", write_data_byte, e.wdb);
        chk("strobe_cycle", cyc, e.due);
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("missing_strobe", write_strobe, e.strobe);
    end
  end

  int ce_mode = 0;
  always @(posedge clock) begin
    #1;
    if (ce_mode == 1) clock_enable = (cyc % 16 == 0);
    else if (ce_mode == 2) clock_enable = ($urandom_range(1, 0) == 1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  task automatic wait_acc(input logic [1:0] mask, output int port, output int t);
    port = -1;
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (|(acc & mask)) begin
        port = acc[1] ? 1 : 0;
        t = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout mask %b got no accept want accept", mask);
  endtask

  task automatic wait_idle(output int c);
    c = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (chip_ready) begin
        c = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout got busy want idle");
  endtask

  initial begin
    int p, t1, t2, c;
    logic [1:0] v;
    logic [15:0] d;

    // Reset state
    clock_enable = 1'b1;
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_strobe", write_strobe, 0);
    chk("rst_bus", internal_data_bus, 0);
    chk("rst_wdb", write_data_byte, 0);
    chk("rst_chip_ready", chip_ready, 1);
    reset = 1'b1;

    // Noise-control latch, then data byte; accepts BT+2 apart with enable tied high
    req_data[7:0] = 8'hE7;
    req_valid = 2'b01;
    wait_acc(2'b01, p, t1);
    chk("t1_strobe_noise_ctrl", write_strobe, 8'h40);
    req_data[7:0] = 8'h2A;
    wait_acc(2'b01, p, t2);
    chk("t1_accept_gap", t2 - t1, BT + 2);
    chk("t1_data_strobe", write_strobe, 8'h40);
    chk("t1_data_flag", write_data_byte, 1);
    req_valid = 2'b00;

    // Both ports continuously valid with data bytes: strict alternation from port 0
    do_reset(2);
    req_data = {8'h10, 8'h20};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_acc(2'b11, p, t1);
      chk("t2_rr_grant", p, k % 2);
      if (p == 0) req_data[7:0] = 8'($urandom) & 8'hFE;
      else req_data[15:8] = 8'($urandom) & 8'hFE;
    end
    req_valid = 2'b00;

    // Lock holds across three idle cycles: port 0 data beats waiting port 1
    req_data[7:0] = 8'h9B;
    req_valid = 2'b01;
    wait_acc(2'b01, p, t1);
    chk("t3_latch_strobe", write_strobe, 8'h08);
    req_data[15:8] = 8'h5C;
    req_valid = 2'b10;
    wait_idle(c);
    repeat (3) tick();
    req_data[7:0] = 8'h04;
    req_valid = 2'b11;
    wait_acc(2'b11, p, t1);
    chk("t3_lock_port", p, 0);
    chk("t3_strobe_tone1_attn", write_strobe, 8'h08);
    chk("t3_data_flag", write_data_byte, 1);
    req_valid = 2'b10;
    wait_acc(2'b10, p, t1);
    chk("t3_port1_after", p, 1);

    // Lock timeout: port 1 granted on the fifth idle cycle
    req_data = {8'h6E, 8'h8D};
    req_valid = 2'b11;
    wait_acc(2'b11, p, t1);
    chk("t4_latch_port", p, 0);
    req_valid = 2'b10;
    wait_idle(c);
    wait_acc(2'b10, p, t2);
    chk("t4_timeout_port", p, 1);
    chk("t4_timeout_gap", t2 - c, LT + 1);
    req_valid = 2'b00;

    // Enable pulsing every 16 clocks stretches the busy window to ~512 clocks
    ce_mode = 1;
    req_data[7:0] = 8'h90;
    req_valid = 2'b01;
    wait_acc(2'b01, p, t1);
    req_data[7:0] = 8'h92;
    wait_acc(2'b01, p, t2);
    chk("t5_gap_in_range", int'((t2 - t1 >= 2 + 31 * 16 + 1) && (t2 - t1 <= 2 + 32 * 16)), 1);
    req_valid = 2'b00;
    ce_mode = 0;
    clock_enable = 1'b1;

    // Reset during ISSUE and during BUSY
    req_data[7:0] = 8'hE7;
    req_valid = 2'b01;
    wait_acc(2'b01, p, t1);
    reset = 1'b0;
    tick();
    chk("t6_issue_rst_strobe", write_strobe, 0);
    chk("t6_issue_rst_bus", internal_data_bus, 0);
    chk("t6_issue_rst_chip_ready", chip_ready, 1);
    reset = 1'b1;
    tick();
    chk("t6_accept_after_release", acc[0], 1);
    repeat (5) tick();
    reset = 1'b0;
    tick();
    chk("t6_busy_rst_strobe", write_strobe, 0);
    chk("t6_busy_rst_chip_ready", chip_ready, 1);
    chk("t6_busy_rst_wdb", write_data_byte, 0);
    reset = 1'b1;
    tick();
    chk("t6_accept_after_busy_release", acc[0], 1);
    req_valid = 2'b00;
    repeat (3) tick();

    // Randomised traffic with random chip ticks, legal valid drops and rare resets
    ce_mode = 2;
    for (int i = 0; i < 5000; i++) begin
      v = req_valid;
      d = req_data;
      for (int q = 0; q < 2; q++) begin
        if (v[q] && !acc[q]) begin
          if ($urandom_range(15, 0) == 0) v[q] = 1'b0;
        end else if (v[q] && acc[q]) begin
          if ($urandom_range(1, 0) == 1) d[q*8 +: 8] = 8'($urandom);
          else v[q] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          v[q] = 1'b1;
          d[q*8 +: 8] = 8'($urandom);
        end
      end
      req_valid = v;
      req_data = d;
      reset = ($urandom_range(699, 0) != 0);
      tick();
    end
    reset = 1'b1;
    req_valid = 2'b00;
    repeat (10) tick();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
